// File: rtl/wb_sonar_scan_master_pkg.sv
`default_nettype none
// ============================================================================
// wb_sonar_scan_master_pkg : shared SonarOnChip Wishbone constants and FSM codes
// Revision : 1.0
// ============================================================================
package wb_sonar_scan_master_pkg;

   localparam logic [31:0] WB_USER_BASE = 32'h3000_0000;
   localparam logic [31:0] WB_CH_STRIDE = 32'h0000_0040;
   localparam int          SONAR_DW     = 16;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_PUSH = 3'd2;
   localparam logic [2:0] ST_NEXT = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Byte address of register idx in channel ch; wraps modulo 2^32.
   function automatic logic [31:0] ch_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [3:0]  ch,
                                           input logic [3:0]  idx);
      ch_addr = base + (32'(ch) * stride) + {26'd0, idx, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_sonar_scan_master.sv
`default_nettype none
// ============================================================================
// wb_sonar_scan_master : Wishbone classic initiator sweeping sonar channel banks
// Revision : 1.0
// ============================================================================
module wb_sonar_scan_master
   import wb_sonar_scan_master_pkg::*;
#(
   parameter int          N_CH      = 10,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0008,
   parameter logic [31:0] CH_STRIDE = WB_CH_STRIDE,
   parameter int          TIMEOUT   = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                start_i,
   input  logic                wr_en_i,
   input  logic [3:0]          reg_idx_i,
   input  logic [15:0]         wr_data_i,
   input  logic                abort_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [14:0]         err_mask_o,
   output logic                m_cyc_o,
   output logic                m_stb_o,
   output logic                m_we_o,
   output logic [3:0]          m_sel_o,
   output logic [31:0]         m_adr_o,
   output logic [31:0]         m_dat_o,
   input  logic                m_ack_i,
   input  logic [31:0]         m_dat_i,
   output logic                rd_valid_o,
   input  logic                rd_ready_i,
   output logic [3:0]          rd_ch_o,
   output logic [SONAR_DW-1:0] rd_data_o,
   output logic                rd_err_o
);

   localparam int             TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0]     CH_LAST  = 4'(N_CH - 1);

   logic [2:0]          state_q, state_d;
   logic [3:0]          ch_q, ch_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                wr_en_q, wr_en_d;
   logic [3:0]          reg_idx_q, reg_idx_d;
   logic [15:0]         wr_data_q, wr_data_d;
   logic [14:0]         err_mask_q, err_mask_d;
   logic                abort_pend_q, abort_pend_d;
   logic                cyc_q, cyc_d;
   logic                we_q, we_d;
   logic [3:0]          sel_q, sel_d;
   logic [31:0]         adr_q, adr_d;
   logic [31:0]         dat_q, dat_d;
   logic                rd_valid_q, rd_valid_d;
   logic [3:0]          rd_ch_q, rd_ch_d;
   logic [SONAR_DW-1:0] rd_data_q, rd_data_d;
   logic                rd_err_q, rd_err_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                launch;
   logic [3:0]          launch_ch;
   logic                launch_we;
   logic [3:0]          launch_idx;
   logic [15:0]         launch_wd;

   logic                unused_dat;
   assign unused_dat = ^m_dat_i[31:16];

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      tmo_d        = tmo_q;
      wr_en_d      = wr_en_q;
      reg_idx_d    = reg_idx_q;
      wr_data_d    = wr_data_q;
      err_mask_d   = err_mask_q;
      abort_pend_d = abort_pend_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      sel_d        = sel_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      rd_valid_d   = rd_valid_q;
      rd_ch_d      = rd_ch_q;
      rd_data_d    = rd_data_q;
      rd_err_d     = rd_err_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      launch       = 1'b0;
      launch_ch    = ch_q + 4'd1;
      launch_we    = wr_en_q;
      launch_idx   = reg_idx_q;
      launch_wd    = wr_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               wr_en_d      = wr_en_i;
               reg_idx_d    = reg_idx_i;
               wr_data_d    = wr_data_i;
               err_mask_d   = '0;
               abort_pend_d = 1'b0;
               busy_d       = 1'b1;
               launch       = 1'b1;
               launch_ch    = 4'd0;
               launch_we    = wr_en_i;
               launch_idx   = reg_idx_i;
               launch_wd    = wr_data_i;
            end
         end
         ST_REQ: begin
            abort_pend_d = abort_pend_q | abort_i;
            // An ack arriving on the last allowed cycle still counts as success.
            if (m_ack_i || (tmo_q == TMO_LAST)) begin
               cyc_d = 1'b0;
               we_d  = 1'b0;
               sel_d = 4'h0;
               dat_d = 32'h0;
               if (!m_ack_i) begin
                  err_mask_d = err_mask_q | (15'd1 << ch_q);
               end
               if (wr_en_q) begin
                  state_d = ST_NEXT;
               end else begin
                  state_d    = ST_PUSH;
                  rd_valid_d = 1'b1;
                  rd_ch_d    = ch_q;
                  rd_err_d   = !m_ack_i;
                  rd_data_d  = m_ack_i ? m_dat_i[SONAR_DW-1:0] : '0;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_PUSH: begin
            abort_pend_d = abort_pend_q | abort_i;
            if (rd_ready_i) begin
               rd_valid_d = 1'b0;
               state_d    = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if ((ch_q == CH_LAST) || abort_i || abort_pend_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               launch = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (launch) begin
         state_d = ST_REQ;
         ch_d    = launch_ch;
         tmo_d   = '0;
         cyc_d   = 1'b1;
         we_d    = launch_we;
         sel_d   = launch_we ? 4'hF : 4'h0;
         adr_d   = ch_addr(BASE_ADDR, CH_STRIDE, launch_ch, launch_idx);
         dat_d   = launch_we ? {{16{launch_wd[15]}}, launch_wd} : 32'h0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q      <= ST_IDLE;
         ch_q         <= '0;
         tmo_q        <= '0;
         wr_en_q      <= 1'b0;
         reg_idx_q    <= '0;
         wr_data_q    <= '0;
         err_mask_q   <= '0;
         abort_pend_q <= 1'b0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         rd_valid_q   <= 1'b0;
         rd_ch_q      <= '0;
         rd_data_q    <= '0;
         rd_err_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         tmo_q        <= tmo_d;
         wr_en_q      <= wr_en_d;
         reg_idx_q    <= reg_idx_d;
         wr_data_q    <= wr_data_d;
         err_mask_q   <= err_mask_d;
         abort_pend_q <= abort_pend_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         rd_valid_q   <= rd_valid_d;
         rd_ch_q      <= rd_ch_d;
         rd_data_q    <= rd_data_d;
         rd_err_q     <= rd_err_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_mask_o = err_mask_q;
   assign m_cyc_o    = cyc_q;
   assign m_stb_o    = cyc_q;
   assign m_we_o     = we_q;
   assign m_sel_o    = sel_q;
   assign m_adr_o    = adr_q;
   assign m_dat_o    = dat_q;
   assign rd_valid_o = rd_valid_q;
   assign rd_ch_o    = rd_ch_q;
   assign rd_data_o  = rd_data_q;
   assign rd_err_o   = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_sonar_scan_master.sv
`default_nettype none
// ============================================================================
// tb_wb_sonar_scan_master : directed table-driven bench with a 1-cycle responder
// Revision : 1.0
// ============================================================================
module tb_wb_sonar_scan_master;

   localparam int N_CH    = 10;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  reg_idx = 4'd0;
   logic [15:0] wr_data = 16'd0;
   logic        abort = 1'b0;
   logic        busy, done;
   logic [14:0] err_mask;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;
   logic        ack_q;
   logic        rd_valid, rd_ready, rd_err;
   logic [3:0]  rd_ch;
   logic [15:0] rd_data;
   logic        stall_en = 1'b0;
   int          dead_ch = -1;

   always #5 clk = ~clk;

   wb_sonar_scan_master #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .start_i(start), .wr_en_i(wr_en),
      .reg_idx_i(reg_idx), .wr_data_i(wr_data), .abort_i(abort),
      .busy_o(busy), .done_o(done), .err_mask_o(err_mask),
      .m_cyc_o(cyc), .m_stb_o(stb), .m_we_o(we), .m_sel_o(sel),
      .m_adr_o(adr), .m_dat_o(dat_o), .m_ack_i(ack_q), .m_dat_i(dat_i),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_ch_o(rd_ch),
      .rd_data_o(rd_data), .rd_err_o(rd_err)
   );

   function automatic int adr2ch(input logic [31:0] a);
      logic [31:0] off;
      off = (a - 32'h3000_0008) >> 6;
      return int'(off[7:0]);
   endfunction

   function automatic logic [15:0] ch_data(input int c);
      int v;
      v = c * 100 - 500;
      return v[15:0];
   endfunction

   // Registered responder: acks one cycle after the strobe, never for dead_ch.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack_q <= 1'b0;
      else        ack_q <= cyc && stb && !ack_q && (adr2ch(adr) != dead_ch);
   end
   assign dat_i    = {16'hA5A5, ch_data(adr2ch(adr))};
   assign rd_ready = !(stall_en && (rd_ch == 4'd2));

   typedef struct {logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;} beat_t;
   typedef struct {logic [3:0] ch; logic [15:0] data; logic err;} res_t;
   beat_t beats[$];
   res_t  results[$];
   int    runs[$];
   int    run_len  = 0;
   int    done_cnt = 0;

   always @(negedge clk) begin
      if (cyc && stb && ack_q) beats.push_back('{adr, we, sel, dat_o});
      if (rd_valid && rd_ready) results.push_back('{rd_ch, rd_data, rd_err});
      if (done) done_cnt++;
      if (cyc) run_len++;
      else if (run_len != 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_logs();
      beats.delete();
      results.delete();
      runs.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start(input logic w, input logic [3:0] idx, input logic [15:0] wd);
      @(posedge clk); #1;
      wr_en = w; reg_idx = idx; wr_data = wd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " done reached"}, done, 1);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        wr;
      logic [3:0]  idx;
      logic [15:0] wd;
      int          dead;
      logic [14:0] mask;
      logic [31:0] adr0;
      logic [31:0] dat;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int ok, k, stable;
      string nm;

      vecs[0] = '{1'b0, 4'd3,  16'h0000, -1, 15'h0000, 32'h3000_0014, 32'h0000_0000};
      vecs[1] = '{1'b0, 4'd3,  16'h0000,  4, 15'h0010, 32'h3000_0014, 32'h0000_0000};
      vecs[2] = '{1'b1, 4'd5,  16'hFFCE, -1, 15'h0000, 32'h3000_001C, 32'hFFFF_FFCE};
      vecs[3] = '{1'b0, 4'd0,  16'h0000,  9, 15'h0200, 32'h3000_0008, 32'h0000_0000};
      vecs[4] = '{1'b1, 4'd15, 16'h1234,  0, 15'h0001, 32'h3000_0044, 32'h0000_1234};

      #12;
      check("reset outputs", {busy, done, err_mask, cyc, stb, we, sel, adr, dat_o,
                              rd_valid, rd_ch, rd_data, rd_err}, '0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      settle();

      // Minimum read latency and first-beat timing.
      clear_logs();
      pulse_start(1'b0, 4'd3, 16'h0);
      check("lat busy", busy, 1);
      check("lat cyc", {cyc, stb, we, sel}, {1'b1, 1'b1, 1'b0, 4'h0});
      check("lat adr", adr, 32'h3000_0014);
      @(posedge clk); #1;
      check("lat valid early", rd_valid, 0);
      @(posedge clk); #1;
      check("lat valid", rd_valid, 1);
      check("lat data ch0", rd_data, 16'hFE0C);
      check("lat cyc dropped", cyc, 0);
      wait_done("lat");
      settle();

      for (int i = 0; i < 5; i++) begin
         clear_logs();
         dead_ch = vecs[i].dead;
         pulse_start(vecs[i].wr, vecs[i].idx, vecs[i].wd);
         wait_done($sformatf("v%0d", i));
         settle();
         check($sformatf("v%0d err_mask", i), err_mask, vecs[i].mask);
         check($sformatf("v%0d done count", i), done_cnt, 1);
         check($sformatf("v%0d busy idle", i), busy, 0);
         check($sformatf("v%0d beats", i), beats.size(), (vecs[i].dead >= 0) ? N_CH - 1 : N_CH);
         k = 0;
         for (int c = 0; c < N_CH; c++) begin
            if (c != vecs[i].dead && k < beats.size()) begin
               nm = $sformatf("v%0d ch%0d", i, c);
               check({nm, " adr"}, beats[k].adr, vecs[i].adr0 + 32'(c) * 32'h40);
               check({nm, " we/sel"}, {beats[k].we, beats[k].sel},
                     {vecs[i].wr, vecs[i].wr ? 4'hF : 4'h0});
               check({nm, " wdat"}, beats[k].dat, vecs[i].dat);
               k++;
            end
         end
         if (!vecs[i].wr) begin
            check($sformatf("v%0d results", i), results.size(), N_CH);
            for (int c = 0; c < N_CH && c < results.size(); c++) begin
               nm = $sformatf("v%0d res%0d", i, c);
               check({nm, " ch"}, results[c].ch, c);
               check({nm, " data"}, results[c].data, (c == vecs[i].dead) ? 16'h0 : ch_data(c));
               check({nm, " err"}, results[c].err, (c == vecs[i].dead) ? 1 : 0);
            end
         end else begin
            check($sformatf("v%0d no results", i), results.size(), 0);
         end
         if (vecs[i].dead >= 0) begin
            check($sformatf("v%0d timeout cyc len", i),
                  (runs.size() > vecs[i].dead) ? runs[vecs[i].dead] : -1, TIMEOUT);
            check($sformatf("v%0d ack cyc len", i),
                  (runs.size() > 5) ? runs[5] : -1, 2);
         end
      end
      dead_ch = -1;

      // Back-pressure on ch2 for 20 cycles.
      clear_logs();
      stall_en = 1'b1;
      pulse_start(1'b0, 4'd3, 16'h0);
      k = 0;
      while (!(rd_valid && rd_ch == 4'd2) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      check("stall reached ch2", {rd_valid, rd_ch}, {1'b1, 4'd2});
      check("stall data", rd_data, 16'hFED4);
      stable = 0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         if (rd_valid && rd_ch == 4'd2 && rd_data == 16'hFED4 && !rd_err && !cyc) stable++;
      end
      check("stall stable cycles", stable, 20);
      check("stall beats held", beats.size(), 3);
      stall_en = 1'b0;
      wait_done("stall");
      settle();
      check("stall results", results.size(), N_CH);

      // Abort during the ch1 request.
      clear_logs();
      pulse_start(1'b0, 4'd3, 16'h0);
      k = 0;
      while (!(cyc && adr2ch(adr) == 1) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("abort reached ch1", {cyc, adr}, {1'b1, 32'h3000_0054});
      abort = 1'b1;
      wait_done("abort");
      abort = 1'b0;
      settle();
      check("abort results", results.size(), 2);
      check("abort last ch", (results.size() > 1) ? results[1].ch : 4'hF, 4'd1);
      check("abort last data", (results.size() > 1) ? results[1].data : 16'h0, 16'hFE70);
      check("abort beats", beats.size(), 2);
      check("abort cyc runs", runs.size(), 2);
      check("abort done count", done_cnt, 1);

      // Reset in the middle of a request.
      clear_logs();
      pulse_start(1'b0, 4'd3, 16'h0);
      k = 0;
      while (!(cyc && adr2ch(adr) == 3) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("rst reached ch3", cyc, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst drops bus", {cyc, stb, busy, rd_valid}, 4'b0000);
      @(posedge clk); #2;
      rst_n = 1'b1;
      settle();
      clear_logs();
      pulse_start(1'b0, 4'd7, 16'h0);
      k = 0;
      while (!(cyc && adr2ch(adr) == 2) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      pulse_start(1'b1, 4'd1, 16'h5555);
      wait_done("restart");
      start = 1'b1; wr_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start in DONE ignored", busy, 0);
      @(posedge clk); #1;
      check("no cyc after DONE start", cyc, 0);
      settle();
      check("restart results", results.size(), N_CH);
      check("restart first ch", (results.size() > 0) ? results[0].ch : 4'hF, 4'd0);
      check("restart first adr", (beats.size() > 0) ? beats[0].adr : 32'h0, 32'h3000_0024);
      check("restart beats", beats.size(), N_CH);
      k = 0;
      foreach (beats[j]) if (beats[j].we) k++;
      check("restart no writes", k, 0);
      check("restart done count", done_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
